dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequencer and arbiter placed in front of the single-port data memory.
- Shares the memory between two requesters:
  - port A: CPU MEM stage.
  - port B: loader/debug master.
- Grants one access at a time and counts a configurable access latency.
- Drives the memory strobes and address, registers the read data, and returns a one-cycle ack per transaction with an out-of-range error flag.

Parameters:
- LATENCY, 1, memory access cycles per transaction (must be >=1).
- DEPTH, 8, number of valid 32-bit words; word address range 0..DEPTH-1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- a_req_i  input  1  port A request, level; held until a_ack_o.
- a_we_i  input  1  port A write (1) / read (0).
- a_addr_i  input  32  port A word address.
- a_wdata_i  input  32  port A write data.
- a_ack_o  output  1  port A completion pulse.
- a_err_o  output  1  port A address error, valid with a_ack_o.
- a_rdata_o  output  32  port A read data, valid with a_ack_o.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_ack_o, b_err_o, b_rdata_o: identical set for port B.
- mem_write_o  output  1  memory write strobe.
- mem_read_o  output  1  memory read enable.
- mem_addr_o  output  32  memory address.
- mem_wdata_o  output  32  memory write data.
- mem_rdata_i  input  32  memory read data (combinational from memory).
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE.
  - All ack, err, mem_write_o, mem_read_o and busy_o = 0.
  - a_rdata_o, b_rdata_o, mem_addr_o, mem_wdata_o = 0.
  - Latency counter = 0.
  - Last-grant pointer = B, so A wins the first contest.
  - Reset mid-transaction abandons it: no ack is issued and any pending write is dropped.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrate on the sampled req lines.
  - Any req present: latch the winner's we, addr and wdata into internal registers, set cnt = LATENCY-1, and go to ACCESS.
  - No req: stay in IDLE.
- Range check at grant:
  - addr >= DEPTH sets the err flag for the transaction.
  - The transaction still passes through ACCESS with both mem strobes held 0 (no memory side effect).
  - It returns rdata = 0.
- ACCESS:
  - mem_addr_o and mem_wdata_o drive the latched values.
  - mem_read_o = 1 throughout for reads when no error.
  - cnt decrements each cycle.
  - In the cycle cnt == 0:
    - mem_write_o = 1 for writes when no error, for exactly that one cycle.
    - For reads, mem_rdata_i is captured into the winner's rdata register at that edge.
    - Next state: DONE.
- DONE:
  - The winner's ack_o = 1 for exactly one cycle; err_o is valid in the same cycle.
  - The non-winner's ack_o and err_o stay 0.
  - Next state: IDLE unconditionally.
  - req still high during DONE is ignored; the requester must drop it after seeing ack.
- Latency: req sampled in IDLE at edge 0 gives ACCESS for cycles 1..LATENCY and ack in cycle LATENCY+1.
- Back-to-back throughput: one transaction per LATENCY+2 cycles.
- rdata holds its last captured value until the next read on that port completes.
- Write transactions leave rdata unchanged.
- Arbitration is evaluated only in IDLE; requests arriving during ACCESS/DONE wait.
- A req that drops before grant is simply not served.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the port not granted last.
  - The last-grant pointer updates at each grant.
  - A single requester is always granted.
- Undefined: fixed priority; A always wins over B, and the last-grant pointer is absent.

Test Plan:
- Write then read, LATENCY=1:
  - A write addr 3, data 0xDEADBEEF: mem_write_o high exactly 1 cycle; a_ack_o in cycle 2; a_err_o = 0.
  - Then A read addr 3: a_rdata_o = 0xDEADBEEF with a_ack_o.
- Latency, LATENCY=4:
  - B read addr 5 (preloaded 0x12345678): mem_read_o high for 4 cycles; b_ack_o in cycle 5; b_rdata_o = 0x12345678; busy_o high cycles 1-5.
- Contention:
  - A and B both request continuously.
  - Macro undefined: A is served every transaction.
  - Macro defined: grants alternate A, B, A, B, with A first after reset.
- Out-of-range:
  - A write addr 8, data 0xFFFFFFFF: a_err_o = 1 with a_ack_o; mem_write_o never asserted.
  - Subsequent reads of addr 0..7 return their prior contents.
  - A read addr 100 returns a_rdata_o = 0 with a_err_o = 1.
- Reset mid-operation, LATENCY=4:
  - Assert rst_i low during cycle 2 of an A write to addr 2: no ack; memory addr 2 is unchanged; after release, busy_o = 0 and state is IDLE.
  - A new request completes normally after release.
- req dropped early:
  - B req pulses for 1 cycle while A's transaction is in ACCESS: B is never granted and b_ack_o stays 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Requester A/B handshakes plus data-memory strobes for dmem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
  logic        a_req_i;
  logic        a_we_i;
  logic [31:0] a_addr_i;
  logic [31:0] a_wdata_i;
  logic        a_ack_o;
  logic        a_err_o;
  logic [31:0] a_rdata_o;

  logic        b_req_i;
  logic        b_we_i;
  logic [31:0] b_addr_i;
  logic [31:0] b_wdata_i;
  logic        b_ack_o;
  logic        b_err_o;
  logic [31:0] b_rdata_o;

  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
    input  mem_rdata_i,
    output a_ack_o, a_err_o, a_rdata_o,
    output b_ack_o, b_err_o, b_rdata_o,
    output mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );

  // Requesters and memory side.
  modport master (
    output a_req_i, a_we_i, a_addr_i, a_wdata_i,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i,
    output mem_rdata_i,
    input  a_ack_o, a_err_o, a_rdata_o,
    input  b_ack_o, b_err_o, b_rdata_o,
    input  mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port sequencer/arbiter for the single-port data memory.
//           Define DMEM_ARB_ROUND_ROBIN_EN for round-robin, else A has priority.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 8
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  dmem_arbiter_if.slave   bus,
  output logic            busy_o
);

  localparam int              c_CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(LATENCY - 1);
  localparam logic [31:0]     c_DEPTH    = 32'(DEPTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic            r_we;
  logic            r_err;
  logic            r_gnt_b;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_a_rdata;
  logic [31:0]     r_b_rdata;

  logic            w_any_req;
  logic            w_gnt_b;
  logic            w_gnt_we;
  logic [31:0]     w_gnt_addr;
  logic [31:0]     w_gnt_wdata;
  logic            w_last_cyc;

  assign w_any_req  = bus.a_req_i | bus.b_req_i;
  assign w_last_cyc = (r_state == c_ACCESS) && (r_cnt == '0);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_b;

  // On contention B wins only when A was granted last.
  assign w_gnt_b = bus.b_req_i & (~bus.a_req_i | ~r_last_b);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last_b <= 1'b1;
    end else if ((r_state == c_IDLE) && w_any_req) begin
      r_last_b <= w_gnt_b;
    end
  end
`else
  assign w_gnt_b = bus.b_req_i & ~bus.a_req_i;
`endif

  assign w_gnt_we    = w_gnt_b ? bus.b_we_i    : bus.a_we_i;
  assign w_gnt_addr  = w_gnt_b ? bus.b_addr_i  : bus.a_addr_i;
  assign w_gnt_wdata = w_gnt_b ? bus.b_wdata_i : bus.a_wdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_any_req) w_state_nxt = c_ACCESS;
      c_ACCESS: if (r_cnt == '0) w_state_nxt = c_DONE;
      c_DONE:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.a_ack_o     = 1'b0;
    bus.b_ack_o     = 1'b0;
    bus.a_err_o     = 1'b0;
    bus.b_err_o     = 1'b0;
    busy_o          = (r_state != c_IDLE);
    case (r_state)
      c_ACCESS: begin
        bus.mem_read_o  = ~r_we & ~r_err;
        bus.mem_write_o = r_we & ~r_err & (r_cnt == '0);
      end
      c_DONE: begin
        bus.a_ack_o = ~r_gnt_b;
        bus.b_ack_o = r_gnt_b;
        bus.a_err_o = ~r_gnt_b & r_err;
        bus.b_err_o = r_gnt_b & r_err;
      end
      default: ;
    endcase
  end

  // Transaction context is latched at grant so requesters may change inputs freely.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if ((r_state == c_IDLE) && w_any_req) begin
        r_gnt_b <= w_gnt_b;
        r_we    <= w_gnt_we;
        r_addr  <= w_gnt_addr;
        r_wdata <= w_gnt_wdata;
        r_err   <= (w_gnt_addr >= c_DEPTH);
        r_cnt   <= c_CNT_INIT;
      end else if ((r_state == c_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Out-of-range reads return zero rather than whatever the memory drives.
      if (w_last_cyc && !r_we) begin
        if (r_gnt_b) begin
          r_b_rdata <= r_err ? 32'd0 : bus.mem_rdata_i;
        end else begin
          r_a_rdata <= r_err ? 32'd0 : bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.a_rdata_o   = r_a_rdata;
  assign bus.b_rdata_o   = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Scoreboard bench for dmem_arbiter; instance 0 uses LATENCY=1,
//           instance 1 uses LATENCY=4, each with its own memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port_b;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req [2], a_we [2], b_req [2], b_we [2];
  logic [31:0] a_addr[2], a_wdata[2], b_addr[2], b_wdata[2];
  logic        a_ack [2], b_ack [2], a_err [2], b_err [2];
  logic        mem_wr[2], mem_rd[2], busy [2];
  logic [31:0] a_rdata[2], b_rdata[2], mem_addr[2];

  logic [31:0] ref_mem [2][8];
  logic [31:0] last_rd [2][2];
  int          wr_cnt[2], rd_cnt[2], busy_cnt[2], aak_cnt[2], bak_cnt[2];
  exp_t        sb_q [2][$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [31:0] init_word(input int k, input int a);
    if (k == 1 && a == 5) return 32'h1234_5678;
    return {16'hC0DE, 8'(k), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    dmem_arbiter_if bus ();
    logic [31:0] mem [8];
    bit          loaded = 1'b0;
    exp_t        e;

    dmem_arbiter #(.LATENCY(gi == 0 ? 1 : 4), .DEPTH(8)) u_dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .bus    (bus),
      .busy_o (busy[gi])
    );

    assign bus.a_req_i   = a_req[gi];
    assign bus.a_we_i    = a_we[gi];
    assign bus.a_addr_i  = a_addr[gi];
    assign bus.a_wdata_i = a_wdata[gi];
    assign bus.b_req_i   = b_req[gi];
    assign bus.b_we_i    = b_we[gi];
    assign bus.b_addr_i  = b_addr[gi];
    assign bus.b_wdata_i = b_wdata[gi];
    assign bus.mem_rdata_i = (bus.mem_addr_o < 32'd8) ? mem[bus.mem_addr_o[2:0]] : 32'hBADC_0DE0;

    assign a_ack[gi]    = bus.a_ack_o;
    assign b_ack[gi]    = bus.b_ack_o;
    assign a_err[gi]    = bus.a_err_o;
    assign b_err[gi]    = bus.b_err_o;
    assign a_rdata[gi]  = bus.a_rdata_o;
    assign b_rdata[gi]  = bus.b_rdata_o;
    assign mem_wr[gi]   = bus.mem_write_o;
    assign mem_rd[gi]   = bus.mem_read_o;
    assign mem_addr[gi] = bus.mem_addr_o;

    always @(posedge clk) begin
      if (!loaded) begin
        for (int a = 0; a < 8; a++) mem[a] <= init_word(gi, a);
        loaded <= 1'b1;
      end else if (bus.mem_write_o && bus.mem_addr_o < 32'd8) begin
        mem[bus.mem_addr_o[2:0]] <= bus.mem_wdata_o;
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (mem_wr[gi]) wr_cnt[gi]++;
        if (mem_rd[gi]) rd_cnt[gi]++;
        if (busy[gi])   busy_cnt[gi]++;
        if (a_ack[gi])  aak_cnt[gi]++;
        if (b_ack[gi])  bak_cnt[gi]++;
        if (a_ack[gi] || b_ack[gi]) begin
          if (sb_q[gi].size() == 0) begin
            chk($sformatf("i%0d_spurious_ack", gi), {30'd0, a_ack[gi], b_ack[gi]}, 32'd0);
          end else begin
            e = sb_q[gi].pop_front();
            chk($sformatf("i%0d_ack_port", gi), {30'd0, a_ack[gi], b_ack[gi]},
                e.port_b ? 32'd1 : 32'd2);
            chk($sformatf("i%0d_ack_err", gi), {30'd0, a_err[gi], b_err[gi]},
                e.port_b ? {31'd0, e.err} : {30'd0, e.err, 1'b0});
            chk($sformatf("i%0d_rdata", gi), e.port_b ? b_rdata[gi] : a_rdata[gi], e.rdata);
          end
        end
      end
    end
  end

  // Predict one transaction's completion and queue it for the monitor.
  task automatic expect_push(input int k, input bit pb, input bit we,
                             input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.port_b = pb;
    e.err    = (addr >= 32'd8);
    if (we)         e.rdata = last_rd[k][pb];
    else if (e.err) e.rdata = 32'd0;
    else            e.rdata = ref_mem[k][addr[2:0]];
    if (we && !e.err) ref_mem[k][addr[2:0]] = wd;
    last_rd[k][pb] = e.rdata;
    sb_q[k].push_back(e);
  endtask

  task automatic drive(input int k, input bit pb, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (pb) begin
      b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd;
    end else begin
      a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd;
    end
  endtask

  task automatic wait_ack(input int k, input bit pb, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      seen = pb ? b_ack[k] : a_ack[k];
    end
  endtask

  // Call at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic txn(input int k, input bit pb, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd);
    int n, lat, wr0, rd0, bz0;
    bit seen, err;
    lat = (k == 0) ? 1 : 4;
    err = (addr >= 32'd8);
    expect_push(k, pb, we, addr, wd);
    wr0 = wr_cnt[k]; rd0 = rd_cnt[k]; bz0 = busy_cnt[k];
    drive(k, pb, 1'b1, we, addr, wd);
    wait_ack(k, pb, n, seen);
    drive(k, pb, 1'b0, 1'b0, 32'd0, 32'd0);
    chk($sformatf("i%0d_ack_cycle", k), seen ? 32'(n - 1) : 32'd999, 32'(lat + 1));
    chk($sformatf("i%0d_write_cycles", k), 32'(wr_cnt[k] - wr0), (we && !err) ? 32'd1 : 32'd0);
    chk($sformatf("i%0d_read_cycles", k), 32'(rd_cnt[k] - rd0), (!we && !err) ? 32'(lat) : 32'd0);
    chk($sformatf("i%0d_busy_cycles", k), 32'(busy_cnt[k] - bz0), 32'(lat + 1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      a_req[k] = 1'b0; b_req[k] = 1'b0;
      sb_q[k].delete();
      last_rd[k][0] = 32'd0; last_rd[k][1] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, acks, a0, w0;
    bit seen, pb;

    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(k, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      wr_cnt[k] = 0; rd_cnt[k] = 0; busy_cnt[k] = 0; aak_cnt[k] = 0; bak_cnt[k] = 0;
      last_rd[k][0] = 32'd0; last_rd[k][1] = 32'd0;
      for (int a = 0; a < 8; a++) ref_mem[k][a] = init_word(k, a);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d_rst_busy", k), {31'd0, busy[k]}, 32'd0);
      chk($sformatf("i%0d_rst_strobes", k), {28'd0, mem_wr[k], mem_rd[k], a_ack[k], b_ack[k]}, 32'd0);
      chk($sformatf("i%0d_rst_a_rdata", k), a_rdata[k], 32'd0);
      chk($sformatf("i%0d_rst_b_rdata", k), b_rdata[k], 32'd0);
      chk($sformatf("i%0d_rst_mem_addr", k), mem_addr[k], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back, single-cycle latency.
    txn(0, 1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF);
    txn(0, 1'b0, 1'b0, 32'd3, 32'd0);

    // Four-cycle latency read from port B.
    txn(1, 1'b1, 1'b0, 32'd5, 32'd0);

    // Out-of-range accesses leave memory untouched and return zero.
    txn(0, 1'b0, 1'b1, 32'd8, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) txn(0, 1'b0, 1'b0, 32'(a), 32'd0);
    txn(0, 1'b0, 1'b0, 32'd100, 32'd0);

    // Port B write/read; A's rdata must survive.
    txn(0, 1'b1, 1'b1, 32'd0, 32'h0BAD_F00D);
    txn(0, 1'b1, 1'b0, 32'd0, 32'd0);
    txn(0, 1'b0, 1'b1, 32'd1, 32'h5555_AAAA);

    // Contention straight after reset: both ports request continuously.
    do_reset();
    for (int j = 0; j < 6; j++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      pb = j[0];
`else
      pb = 1'b0;
`endif
      expect_push(0, pb, 1'b0, pb ? 32'd6 : 32'd1, 32'd0);
    end
    drive(0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'd6, 32'd0);
    acks = 0;
    n = 0;
    while (acks < 6 && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (a_ack[0] || b_ack[0]) acks++;
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("contention_acks", 32'(acks), 32'd6);
    repeat (4) @(posedge clk);
    #1;
    chk("contention_drain", 32'(sb_q[0].size()), 32'd0);

    // Reset during cycle 2 of a four-cycle write abandons it.
    a0 = aak_cnt[1];
    w0 = wr_cnt[1];
    drive(1, 1'b0, 1'b1, 1'b1, 32'd2, 32'hBAD0_BAD0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("midrst_busy_low", {31'd0, busy[1]}, 32'd0);
    chk("midrst_strobes", {29'd0, mem_wr[1], mem_rd[1], a_ack[1]}, 32'd0);
    chk("midrst_mem_addr", mem_addr[1], 32'd0);
    for (int k = 0; k < 2; k++) begin
      sb_q[k].delete();
      last_rd[k][0] = 32'd0; last_rd[k][1] = 32'd0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_ack", 32'(aak_cnt[1] - a0), 32'd0);
    chk("midrst_no_write", 32'(wr_cnt[1] - w0), 32'd0);
    chk("midrst_mem_kept", g_inst[1].mem[2], init_word(1, 2));
    chk("midrst_idle", {31'd0, busy[1]}, 32'd0);
    txn(1, 1'b0, 1'b0, 32'd2, 32'd0);

    // B pulses req for one cycle while A is in ACCESS: B is never served.
    a0 = bak_cnt[1];
    expect_push(1, 1'b0, 1'b0, 32'd4, 32'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'd7, 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(1, 1'b0, n, seen);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("early_drop_a_ack", {31'd0, seen}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("early_drop_no_b_ack", 32'(bak_cnt[1] - a0), 32'd0);

    chk("i0_sb_empty", 32'(sb_q[0].size()), 32'd0);
    chk("i1_sb_empty", 32'(sb_q[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
